// File: rtl/spi_slave_ram_ctrl.sv
// SPI-slave front end for the single-port command RAM: deserialises command
// frames, strobes them out as rx_data/rx_valid, and serialises read data on MISO.
module spi_slave_ram_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int TX_WAIT_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic [DATA_WIDTH+1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid
);

  localparam int FW = DATA_WIDTH + 2;
  localparam int CW = $clog2(FW + 1);
  localparam int SW = $clog2(((DATA_WIDTH > TX_WAIT_MAX) ? DATA_WIDTH : TX_WAIT_MAX) + 1);

  localparam logic [CW-1:0] LAST_BIT   = CW'(FW - 1);
  localparam logic [CW-1:0] FRAME_DONE = CW'(FW);
  localparam logic [SW-1:0] WAIT_LAST  = SW'(TX_WAIT_MAX - 1);
  localparam logic [SW-1:0] OUT_LAST   = SW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_e;
  typedef enum logic [1:0] {SHIFT_IN, WAIT_TX, SHIFT_OUT, DONE} phase_e;

  state_e                state_q;
  phase_e                phase_q;
  logic [CW-1:0]         cnt_q;
  logic [SW-1:0]         sub_q;
  logic [FW-2:0]         shreg_q;
  logic [DATA_WIDTH-2:0] tx_shreg_q;
  logic                  rd_addr_done_q;
  logic                  miso_q;
  logic [FW-1:0]         rx_data_q;
  logic                  rx_valid_q;

  assign miso     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      phase_q        <= SHIFT_IN;
      cnt_q          <= '0;
      sub_q          <= '0;
      shreg_q        <= '0;
      tx_shreg_q     <= '0;
      rd_addr_done_q <= 1'b0;
      miso_q         <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      // Deselect aborts any frame in progress, including on the bit-0 edge.
      if (state_q != IDLE && ss_n) begin
        state_q <= IDLE;
        phase_q <= SHIFT_IN;
        miso_q  <= 1'b0;
        cnt_q   <= '0;
        sub_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (!ss_n) begin
              state_q <= CHK_CMD;
              phase_q <= SHIFT_IN;
              cnt_q   <= '0;
            end
          end
          CHK_CMD: begin
            shreg_q <= {shreg_q[FW-3:0], mosi};
            cnt_q   <= CW'(1);
            if (!mosi)               state_q <= WRITE;
            else if (rd_addr_done_q) state_q <= READ_DATA;
            else                     state_q <= READ_ADD;
          end
          WRITE, READ_ADD: begin
            if (cnt_q == LAST_BIT) begin
              rx_data_q  <= {shreg_q, mosi};
              rx_valid_q <= 1'b1;
              cnt_q      <= FRAME_DONE;
              if (state_q == READ_ADD) rd_addr_done_q <= 1'b1;
            end else if (cnt_q != FRAME_DONE) begin
              shreg_q <= {shreg_q[FW-3:0], mosi};
              cnt_q   <= cnt_q + 1'b1;
            end
          end
          READ_DATA: begin
            case (phase_q)
              SHIFT_IN: begin
                if (cnt_q == LAST_BIT) begin
                  rx_data_q  <= {shreg_q, mosi};
                  rx_valid_q <= 1'b1;
                  cnt_q      <= FRAME_DONE;
                  phase_q    <= WAIT_TX;
                  sub_q      <= '0;
                end else begin
                  shreg_q <= {shreg_q[FW-3:0], mosi};
                  cnt_q   <= cnt_q + 1'b1;
                end
              end
              WAIT_TX: begin
                if (tx_valid) begin
                  tx_shreg_q <= tx_data[DATA_WIDTH-2:0];
                  miso_q     <= tx_data[DATA_WIDTH-1];
                  sub_q      <= '0;
                  phase_q    <= SHIFT_OUT;
                end else if (sub_q == WAIT_LAST) begin
                  // Timed out: rd_addr_done stays set so the read can be retried.
                  miso_q  <= 1'b0;
                  phase_q <= DONE;
                end else begin
                  sub_q <= sub_q + 1'b1;
                end
              end
              SHIFT_OUT: begin
                if (sub_q == OUT_LAST) begin
                  miso_q         <= 1'b0;
                  rd_addr_done_q <= 1'b0;
                  phase_q        <= DONE;
                end else begin
                  miso_q     <= tx_shreg_q[DATA_WIDTH-2];
                  tx_shreg_q <= tx_shreg_q << 1;
                  sub_q      <= sub_q + 1'b1;
                end
              end
              default: miso_q <= 1'b0;
            endcase
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ram_ctrl.sv
// Directed bench for spi_slave_ram_ctrl: frame capture, read sequencing,
// aborts, tx_valid timeout and mid-frame reset.
module tb_spi_slave_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, ss_n, mosi, miso, rx_valid, tx_valid;
  logic [9:0] rx_data;
  logic [7:0] tx_data;

  int total = 0;
  int bad   = 0;
  int rv_cnt = 0;
  int miso_hi = 0;

  spi_slave_ram_ctrl #(.DATA_WIDTH(8), .TX_WAIT_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  // Pulse/level monitors sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_valid) rv_cnt++;
    if (miso) miso_hi++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input logic [9:0] f);
    ss_n = 1'b0;
    tick;
    for (int i = 9; i >= 0; i--) begin
      mosi = f[i];
      tick;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ss_n = 1'b0; mosi = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
    tick;
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso: got %b want 0", miso); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    total++; if (rx_data !== 10'h000) begin bad++; $display("FAIL reset_rx_data: got %h want 000", rx_data); end
    do_reset;
  endtask

  task automatic test_basic_frame;
    int r0, m0;
    do_reset;
    r0 = rv_cnt; m0 = miso_hi;
    send_frame(10'h02A);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL basic_rx_valid: got %b want 1", rx_valid); end
    total++; if (rx_data !== 10'h02A) begin bad++; $display("FAIL basic_rx_data: got %h want 02a", rx_data); end
    tick;
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL basic_rx_valid_drop: got %b want 0", rx_valid); end
    tick; tick;
    ss_n = 1'b1; tick;
    total++; if (rv_cnt - r0 !== 1) begin bad++; $display("FAIL basic_pulse_count: got %0d want 1", rv_cnt - r0); end
    total++; if (miso_hi - m0 !== 0) begin bad++; $display("FAIL basic_miso_quiet: got %0d want 0", miso_hi - m0); end
  endtask

  task automatic test_write_frame;
    int r0, m0;
    do_reset;
    r0 = rv_cnt; m0 = miso_hi;
    tx_valid = 1'b1; tx_data = 8'hFF;
    send_frame(10'h1C3);
    total++; if (rx_data !== 10'h1C3) begin bad++; $display("FAIL write_rx_data: got %h want 1c3", rx_data); end
    tick;
    ss_n = 1'b1; tick;
    total++; if (rv_cnt - r0 !== 1) begin bad++; $display("FAIL write_pulse_count: got %0d want 1", rv_cnt - r0); end
    // rd_addr_done must still be 0: a bit9=1 frame is a read-address, so no MISO data.
    send_frame(10'h200);
    tick; tick; tick;
    ss_n = 1'b1; tick;
    tx_valid = 1'b0;
    total++; if (miso_hi - m0 !== 0) begin bad++; $display("FAIL write_no_read_data: got %0d want 0", miso_hi - m0); end
  endtask

  task automatic test_read_sequence;
    logic [7:0] expd;
    int m0;
    do_reset;
    send_frame(10'h22A);
    ss_n = 1'b1; tick;
    send_frame(10'h300);
    total++; if (rx_data !== 10'h300) begin bad++; $display("FAIL rd_rx_data: got %h want 300", rx_data); end
    expd = 8'hA5;
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0; tx_data = 8'h00;
    total++; if (miso !== expd[7]) begin bad++; $display("FAIL rd_miso_b7: got %b want %b", miso, expd[7]); end
    for (int i = 6; i >= 0; i--) begin
      tick;
      total++; if (miso !== expd[i]) begin bad++; $display("FAIL rd_miso_b%0d: got %b want %b", i, miso, expd[i]); end
    end
    tick;
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL rd_miso_after_lsb: got %b want 0", miso); end
    ss_n = 1'b1; tick;
    // rd_addr_done cleared: next bit9=1 frame is a read-address and ignores tx_valid.
    m0 = miso_hi;
    send_frame(10'h300);
    tx_valid = 1'b1; tx_data = 8'hFF;
    tick; tick; tick;
    tx_valid = 1'b0;
    ss_n = 1'b1; tick;
    total++; if (miso_hi - m0 !== 0) begin bad++; $display("FAIL rd_addr_done_cleared: got %0d want 0", miso_hi - m0); end
  endtask

  task automatic test_abort;
    logic [9:0] f;
    logic [7:0] expd;
    int r0;
    do_reset;
    send_frame(10'h22A);
    ss_n = 1'b1; tick;
    r0 = rv_cnt;
    ss_n = 1'b0; tick;
    f = 10'b11010_00000;
    for (int i = 9; i >= 5; i--) begin mosi = f[i]; tick; end
    ss_n = 1'b1; tick; tick;
    total++; if (rv_cnt - r0 !== 0) begin bad++; $display("FAIL abort_partial: got %0d pulses want 0", rv_cnt - r0); end
    // Deselect on the bit-0 edge: abort wins.
    f = 10'h2FF;
    ss_n = 1'b0; tick;
    for (int i = 9; i >= 1; i--) begin mosi = f[i]; tick; end
    mosi = f[0]; ss_n = 1'b1; tick;
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL abort_bit0: got %b want 0", rx_valid); end
    tick;
    total++; if (rv_cnt - r0 !== 0) begin bad++; $display("FAIL abort_bit0_count: got %0d want 0", rv_cnt - r0); end
    // rd_addr_done survived both aborts, so this frame is a read-data.
    send_frame(10'h300);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL abort_retry_valid: got %b want 1", rx_valid); end
    expd = 8'h81;
    tx_data = 8'h81; tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0;
    total++; if (miso !== expd[7]) begin bad++; $display("FAIL abort_retry_b7: got %b want %b", miso, expd[7]); end
    for (int i = 6; i >= 0; i--) begin
      tick;
      total++; if (miso !== expd[i]) begin bad++; $display("FAIL abort_retry_b%0d: got %b want %b", i, miso, expd[i]); end
    end
    ss_n = 1'b1; tick;
  endtask

  task automatic test_timeout;
    int m0;
    do_reset;
    send_frame(10'h22A);
    ss_n = 1'b1; tick;
    send_frame(10'h300);
    m0 = miso_hi;
    tx_valid = 1'b0;
    tick; tick; tick; tick;
    tx_valid = 1'b1; tx_data = 8'hFF;
    tick; tick;
    tx_valid = 1'b0;
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL timeout_miso: got %b want 0", miso); end
    total++; if (miso_hi - m0 !== 0) begin bad++; $display("FAIL timeout_late_tx: got %0d want 0", miso_hi - m0); end
    ss_n = 1'b1; tick;
    // Retry still a read-data; tx_valid on the 4th wait edge is in time.
    send_frame(10'h300);
    total++; if (rx_data !== 10'h300) begin bad++; $display("FAIL timeout_retry_rx: got %h want 300", rx_data); end
    tick; tick; tick;
    tx_valid = 1'b1; tx_data = 8'hC0;
    tick;
    tx_valid = 1'b0;
    total++; if (miso !== 1'b1) begin bad++; $display("FAIL timeout_retry_b7: got %b want 1", miso); end
    tick;
    total++; if (miso !== 1'b1) begin bad++; $display("FAIL timeout_retry_b6: got %b want 1", miso); end
    ss_n = 1'b1; tick;
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL timeout_abort_miso: got %b want 0", miso); end
  endtask

  task automatic test_reset_midframe;
    logic [9:0] f;
    do_reset;
    send_frame(10'h1C3);
    tick;
    ss_n = 1'b1; tick;
    f = 10'h0FF;
    ss_n = 1'b0; tick;
    for (int i = 9; i >= 7; i--) begin mosi = f[i]; tick; end
    mosi = f[6]; rst_n = 1'b0;
    tick;
    total++; if (rx_data !== 10'h000) begin bad++; $display("FAIL midrst_rx_data: got %h want 000", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL midrst_rx_valid: got %b want 0", rx_valid); end
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL midrst_miso: got %b want 0", miso); end
    rst_n = 1'b1; ss_n = 1'b1; tick;
    send_frame(10'h055);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL midrst_fresh_valid: got %b want 1", rx_valid); end
    total++; if (rx_data !== 10'h055) begin bad++; $display("FAIL midrst_fresh_data: got %h want 055", rx_data); end
    ss_n = 1'b1; tick;
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_write_frame;
    test_read_sequence;
    test_abort;
    test_timeout;
    test_reset_midframe;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_slave_ram_ctrl.md
Name: spi_slave_ram_ctrl

Overview:
- SPI-slave front end that sequences the single-port command RAM.
- Deserialises 10-bit command frames from MOSI and presents each one to the RAM as rx_data with a one-cycle rx_valid pulse.
- For read-data commands, waits for the RAM's tx_valid, captures tx_data and serialises it MSB-first on MISO.
- Tracks read-address/read-data ordering so that each read is a two-frame sequence.

Parameters:
DATA_WIDTH, 8, RAM data/address width; frame width is DATA_WIDTH+2.
TX_WAIT_MAX, 4, max cycles to wait for tx_valid after a read-data frame before abandoning the read.

Ports:
clk  in  1  SPI clock; all logic on posedge.
rst_n  in  1  synchronous, active-low reset.
ss_n  in  1  slave select, active low; frame framing.
mosi  in  1  serial data in, MSB first.
miso  out  1  serial data out, registered.
rx_data  out  DATA_WIDTH+2  assembled command frame {cmd[1:0], payload}.
rx_valid  out  1  one-cycle strobe, rx_data valid.
tx_data  in  DATA_WIDTH  read data from RAM.
tx_valid  in  1  RAM read-data valid.

Behaviour:
- Reset: clk and rst_n, synchronous, active-low. On reset: state=IDLE, miso=0, rx_data=0, rx_valid=0, rd_addr_done=0, bit counter=0. Reset overrides everything, including mid-frame.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
  - In READ_DATA, a sub-phase register tracks SHIFT_IN / WAIT_TX / SHIFT_OUT / DONE.
- IDLE -> CHK_CMD on the edge that samples ss_n=0.
- CHK_CMD: the edge samples mosi as frame bit 9 into the shift register, then transitions:
  - mosi=0 -> WRITE.
  - mosi=1 and rd_addr_done=0 -> READ_ADD.
  - mosi=1 and rd_addr_done=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA (SHIFT_IN): capture bits 8..0 on the next 9 edges, one per edge.
  - On the edge capturing bit 0: rx_data <= {shreg, mosi} and rx_valid <= 1.
  - rx_valid returns to 0 on the following edge. It is never high for more than 1 cycle.
- rx_data is forwarded verbatim. The FSM state choice uses only bit 9 and rd_addr_done; bit 8 is not interpreted here.
- After the rx_valid edge, WRITE and READ_ADD hold with counter frozen until ss_n=1, then go to IDLE.
  - READ_ADD sets rd_addr_done=1 on the rx_valid edge.
- READ_DATA after rx_valid enters WAIT_TX.
  - The first edge sampling tx_valid=1 loads tx_data into tx_shreg and drives miso <= tx_data[DATA_WIDTH-1].
  - The next DATA_WIDTH-1 edges drive the remaining bits, MSB to LSB.
  - The edge after the LSB drives miso=0, clears rd_addr_done and enters DONE. DONE holds until ss_n=1.
- WAIT_TX timeout: if tx_valid is not seen within TX_WAIT_MAX edges, enter DONE with miso=0 and leave rd_addr_done=1 so the read can be retried.
- tx_valid sampled outside WAIT_TX is ignored.
- ss_n=1 sampled in any non-IDLE state:
  - Next state is IDLE; miso=0; counter cleared; partial frame discarded (no rx_valid).
  - rd_addr_done is unchanged, unless the frame had completed per the rules above.
  - ss_n=1 on the same edge as bit 0: the abort wins and no rx_valid is issued.
- miso is 0 whenever not in SHIFT_OUT.

Test Plan:
- Reset, ss_n=0, mosi bits 0,0,0x2A MSB-first -> after 10 edges rx_data=10'h02A and rx_valid high exactly 1 cycle; miso stays 0.
- Write-data frame 0,1,0xC3 -> rx_data=10'h1C3 with a single rx_valid pulse; rd_addr_done stays 0.
- Read-address frame 1,0,0x2A, deassert ss_n, then read-data frame 1,1,0x00, RAM returns tx_valid=1 with tx_data=0xA5 one cycle after rx_valid -> miso sequence 1,0,1,0,0,1,0,1 on consecutive edges, then 0; rd_addr_done cleared.
- Read-address frame, then ss_n raised after 5 bits of the following frame -> no rx_valid; next frame starting with 1 still goes to READ_DATA (rd_addr_done=1).
- Read-data frame with tx_valid never asserted -> after TX_WAIT_MAX=4 edges FSM enters DONE with miso=0; rd_addr_done remains 1.
- rst_n=0 on bit 6 of a write frame -> all outputs 0 next edge; a fresh frame after reset decodes correctly with no stale bits.
